// File: rtl/tri_bus_port.sv
// tri_bus_port: bidirectional bus port for a WIDTH-bit tri-state GPIO pad.
//
// The pad is split into pad_in / pad_out / pad_oe. Core logic writes words
// through a valid/ready interface and reads the bus through a request/valid
// interface. The port owns the bus direction: every written word is driven
// for HOLD_CYCLES cycles, followed by TURN_CYCLES released cycles before the
// port returns to idle. Reads release the bus for SYNC_STAGES cycles and then
// capture the synchronised pad value.
//
// Ports:
//   clk            sole clock
//   rst            asynchronous active-high reset
//   pad_in         value from the GPIO input buffer (asynchronous to clk)
//   pad_out        value to the GPIO output buffer (registered)
//   pad_oe         per-bit output enable, all bits equal (registered)
//   wr_valid       write word offered
//   wr_data        write word
//   wr_ready       write accepted when wr_valid && wr_ready
//   rd_req         read request, level, sampled only in IDLE
//   rd_valid       one-cycle pulse, rd_data valid
//   rd_data        captured bus value, held until the next read completes
//   busy           high in any state other than IDLE
//   err_clr        clears contention_err
//   contention_err sticky drive/readback mismatch flag
//
// Optional feature macro: TRI_BUS_READBACK_CHECK_EN
//   Defined   : on the last DRIVE cycle the synchronised pad value is
//               compared with pad_out; a mismatch sets contention_err.
//               Requires HOLD_CYCLES > SYNC_STAGES.
//   Undefined : comparator removed, contention_err tied 0, err_clr ignored.

module tri_bus_port #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned TURN_CYCLES = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] pad_out,
    output logic [WIDTH-1:0] pad_oe,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_req,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    input  logic             err_clr,
    output logic             contention_err
);

    // Counter covers the longest of the three timed states.
    localparam int unsigned CNT_MAX_HT = (HOLD_CYCLES > TURN_CYCLES) ? HOLD_CYCLES : TURN_CYCLES;
    localparam int unsigned CNT_MAX    = (CNT_MAX_HT > SYNC_STAGES) ? CNT_MAX_HT : SYNC_STAGES;
    localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_STAGES - 1);

    // Parameter legality checks
    generate
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("tri_bus_port: HOLD_CYCLES must be at least 1");
        end
        if (TURN_CYCLES < 1) begin : g_bad_turn
            $error("tri_bus_port: TURN_CYCLES must be at least 1");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("tri_bus_port: SYNC_STAGES must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_TURN   = 2'd2,
        S_SAMPLE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_last;
    logic               w_load;
    logic               w_capture;
    logic               w_wr_acc;
    logic               w_ready_nxt;

    logic [WIDTH-1:0]   r_sync [SYNC_STAGES];
    logic [WIDTH-1:0]   w_sync_q;

    logic [WIDTH-1:0]   r_pad_out;
    logic               r_oe;
    logic               r_wr_ready;
    logic               r_rd_valid;
    logic [WIDTH-1:0]   r_rd_data;
    logic               r_busy;

    // pad_in synchroniser chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= pad_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sync_q = r_sync[SYNC_STAGES-1];

    // Handshake uses the registered ready so a word is only taken when the
    // core actually saw wr_ready high.
    assign w_wr_acc = wr_valid && r_wr_ready;

    // Last cycle of the current timed state
    always_comb begin
        w_last = 1'b0;
        case (r_state)
            S_DRIVE:  w_last = (r_cnt == HOLD_LAST);
            S_TURN:   w_last = (r_cnt == TURN_LAST);
            S_SAMPLE: w_last = (r_cnt == SYNC_LAST);
            default:  w_last = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; counter restarts at 0 on every state entry
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_load      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_wr_acc) begin
                    w_state_nxt = S_DRIVE;
                    w_load      = 1'b1;
                end else if (rd_req) begin
                    w_state_nxt = S_SAMPLE;
                end
            end
            S_DRIVE: begin
                if (w_last) begin
                    w_cnt_nxt = '0;
                    if (w_wr_acc) begin
                        // Follow-on word: restart DRIVE with no gap
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = S_TURN;
                    end
                end
            end
            S_TURN: begin
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            S_SAMPLE: begin
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    w_capture   = 1'b1;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Ready in the coming cycle: IDLE, or the last cycle of a DRIVE
    assign w_ready_nxt = (w_state_nxt == S_IDLE) ||
                         ((w_state_nxt == S_DRIVE) && (w_cnt_nxt == HOLD_LAST));

    // Output registers, all derived from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pad_out  <= '0;
            r_oe       <= 1'b0;
            r_wr_ready <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_busy     <= 1'b0;
        end else begin
            if (w_load) begin
                r_pad_out <= wr_data;
            end
            if (w_capture) begin
                r_rd_data <= w_sync_q;
            end
            r_oe       <= (w_state_nxt == S_DRIVE);
            r_wr_ready <= w_ready_nxt;
            r_rd_valid <= w_capture;
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

    assign pad_out  = r_pad_out;
    assign pad_oe   = {WIDTH{r_oe}};
    assign wr_ready = r_wr_ready;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign busy     = r_busy;

`ifdef TRI_BUS_READBACK_CHECK_EN
    // The synchroniser must have seen the driven word by the last DRIVE cycle
    generate
        if (HOLD_CYCLES <= SYNC_STAGES) begin : g_bad_readback
            $error("tri_bus_port: readback check requires HOLD_CYCLES > SYNC_STAGES");
        end
    endgenerate

    logic r_err;
    logic w_mismatch;

    assign w_mismatch = (r_state == S_DRIVE) && w_last && (w_sync_q != r_pad_out);

    // Sticky flag; a new mismatch wins over a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_mismatch) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign contention_err = r_err;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr;
    assign contention_err   = 1'b0;
`endif

endmodule

// File: tb/tb_tri_bus_port.sv
// Testbench for tri_bus_port: directed vector table, hand-written corner
// sequences (back-to-back writes, readback contention, async reset) and a
// randomized run checked against a timeline model of the port.

module tb_tri_bus_port;

    localparam int unsigned W = 8;
`ifdef TRI_BUS_READBACK_CHECK_EN
    localparam int unsigned H  = 3;
    localparam bit          RB = 1'b1;
`else
    localparam int unsigned H  = 2;
    localparam bit          RB = 1'b0;
`endif
    localparam int unsigned T = 1;
    localparam int unsigned S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] pad_in;
    logic [W-1:0] pad_out;
    logic [W-1:0] pad_oe;
    logic         wr_valid = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         wr_ready;
    logic         rd_req = 1'b0;
    logic         rd_valid;
    logic [W-1:0] rd_data;
    logic         busy;
    logic         err_clr = 1'b0;
    logic         contention_err;

    // Pad model: loops back the driven value, else an external bus value
    logic [W-1:0] ext_val   = '0;
    logic         force_ext = 1'b0;

    assign pad_in = (pad_oe[0] && !force_ext) ? pad_out : ext_val;

    tri_bus_port #(
        .WIDTH       (W),
        .HOLD_CYCLES (H),
        .TURN_CYCLES (T),
        .SYNC_STAGES (S)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pad_in         (pad_in),
        .pad_out        (pad_out),
        .pad_oe         (pad_oe),
        .wr_valid       (wr_valid),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .rd_req         (rd_req),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .busy           (busy),
        .err_clr        (err_clr),
        .contention_err (contention_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic         wv;
        logic [W-1:0] wd;
        logic         rq;
        logic [W-1:0] ext;
        logic         oe;
        logic [W-1:0] out;
        logic         rdy;
        logic         bsy;
        logic         rdv;
        logic [W-1:0] rdata;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic oe, input logic [W-1:0] out,
                           input logic rdy, input logic bsy, input logic rdv,
                           input logic [W-1:0] rdata, input logic err);
        chk({tag, " pad_oe"},         32'(pad_oe),         32'({W{oe}}));
        chk({tag, " pad_out"},        32'(pad_out),        32'(out));
        chk({tag, " wr_ready"},       32'(wr_ready),       32'(rdy));
        chk({tag, " busy"},           32'(busy),           32'(bsy));
        chk({tag, " rd_valid"},       32'(rd_valid),       32'(rdv));
        chk({tag, " rd_data"},        32'(rd_data),        32'(rdata));
        chk({tag, " contention_err"}, 32'(contention_err), 32'(err));
    endtask

    function automatic void add(input logic wv, input logic [W-1:0] wd, input logic rq,
                                input logic [W-1:0] ext, input logic oe, input logic [W-1:0] out,
                                input logic rdy, input logic bsy, input logic rdv,
                                input logic [W-1:0] rdata);
        vec_t v;
        v.wv = wv; v.wd = wd; v.rq = rq; v.ext = ext;
        v.oe = oe; v.out = out; v.rdy = rdy; v.bsy = bsy; v.rdv = rdv; v.rdata = rdata;
        tbl.push_back(v);
    endfunction

    // Timeline model state for the random run
    int           busy_end, drv_first, drv_last, rdv_cyc, nout_at;
    logic [W-1:0] m_out, m_nout, m_rd, m_rdn;
    logic         m_idle, m_ready, m_oe;
    logic [W-1:0] words [3];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        // ---------------- reset state ----------------
        ext_val = 8'h3C;
        step(); step();
        chk_all("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        step();

        // ---------------- directed vector table ----------------
        // Each row: outputs expected in this cycle, then inputs for this cycle.
        add(1, 8'hA5, 0, 8'h3C,  0, 8'h00, 1, 0, 0, 8'h00);
        add(0, 8'h00, 0, 8'h3C,  1, 8'hA5, 0, 1, 0, 8'h00);
`ifdef TRI_BUS_READBACK_CHECK_EN
        add(0, 8'h00, 0, 8'h3C,  1, 8'hA5, 0, 1, 0, 8'h00);
`endif
        add(0, 8'h00, 0, 8'h3C,  1, 8'hA5, 1, 1, 0, 8'h00);
        add(0, 8'h00, 0, 8'h3C,  0, 8'hA5, 0, 1, 0, 8'h00);
        add(0, 8'h00, 1, 8'h3C,  0, 8'hA5, 1, 0, 0, 8'h00);
        add(0, 8'h00, 0, 8'h3C,  0, 8'hA5, 0, 1, 0, 8'h00);
        add(0, 8'h00, 0, 8'h3C,  0, 8'hA5, 0, 1, 0, 8'h00);
        add(1, 8'h5A, 1, 8'h3C,  0, 8'hA5, 1, 0, 1, 8'h3C);
        add(0, 8'h00, 1, 8'hC3,  1, 8'h5A, 0, 1, 0, 8'h3C);
`ifdef TRI_BUS_READBACK_CHECK_EN
        add(0, 8'h00, 1, 8'hC3,  1, 8'h5A, 0, 1, 0, 8'h3C);
`endif
        add(0, 8'h00, 1, 8'hC3,  1, 8'h5A, 1, 1, 0, 8'h3C);
        add(0, 8'h00, 1, 8'hC3,  0, 8'h5A, 0, 1, 0, 8'h3C);
        add(0, 8'h00, 1, 8'hC3,  0, 8'h5A, 1, 0, 0, 8'h3C);
        add(0, 8'h00, 0, 8'hC3,  0, 8'h5A, 0, 1, 0, 8'h3C);
        add(0, 8'h00, 0, 8'hC3,  0, 8'h5A, 0, 1, 0, 8'h3C);
        add(0, 8'h00, 0, 8'hC3,  0, 8'h5A, 1, 0, 1, 8'hC3);
        add(0, 8'h00, 0, 8'hC3,  0, 8'h5A, 1, 0, 0, 8'hC3);

        for (int i = 0; i < tbl.size(); i++) begin
            chk_all($sformatf("vec%0d", i), tbl[i].oe, tbl[i].out, tbl[i].rdy,
                    tbl[i].bsy, tbl[i].rdv, tbl[i].rdata, 1'b0);
            wr_valid = tbl[i].wv;
            wr_data  = tbl[i].wd;
            rd_req   = tbl[i].rq;
            ext_val  = tbl[i].ext;
            step();
        end
        wr_valid = 1'b0;
        rd_req   = 1'b0;

        // ---------------- back-to-back writes ----------------
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        begin
            int idx;
            idx = 0;
            chk("b2b start ready", 32'(wr_ready), 32'd1);
            wr_valid = 1'b1;
            wr_data  = words[0];
            for (int c = 1; c <= int'(3*H + T + 1); c++) begin
                logic         e_oe, e_rdy;
                logic [W-1:0] e_out;
                int           wi;
                step();
                wi    = (c - 1) / int'(H);
                if (wi > 2) wi = 2;
                e_oe  = (c <= int'(3*H));
                e_out = words[wi];
                e_rdy = ((c % int'(H)) == 0 && c <= int'(3*H)) || (c > int'(3*H + T));
                chk($sformatf("b2b c%0d pad_oe", c),   32'(pad_oe),   32'({W{e_oe}}));
                chk($sformatf("b2b c%0d pad_out", c),  32'(pad_out),  32'(e_out));
                chk($sformatf("b2b c%0d wr_ready", c), 32'(wr_ready), 32'(e_rdy));
                chk($sformatf("b2b c%0d busy", c),     32'(busy),     32'(c <= int'(3*H + T)));
                if (wr_valid && e_rdy) begin
                    idx++;
                    if (idx >= 3) wr_valid = 1'b0;
                    else          wr_data  = words[idx];
                end
            end
            wr_valid = 1'b0;
        end

        // ---------------- readback contention ----------------
        force_ext = 1'b1;
        ext_val   = 8'h00;
        wr_valid  = 1'b1;
        wr_data   = 8'hFF;
        step();
        wr_valid = 1'b0;
        for (int c = 1; c < int'(H); c++) step();
        chk("rb last drive err", 32'(contention_err), 32'd0);
        step();
        chk("rb after drive err", 32'(contention_err), 32'(RB));
        step();
        chk("rb held err", 32'(contention_err), 32'(RB));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("rb cleared err", 32'(contention_err), 32'd0);
        repeat (4) step();
        // Clear in the same cycle as a mismatch: flag must stay set
        chk("rb2 idle ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_data  = 8'hF0;
        step();
        wr_valid = 1'b0;
        for (int c = 1; c < int'(H); c++) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("rb clr+mismatch err", 32'(contention_err), 32'(RB));
        repeat (4) step();
        force_ext = 1'b0;

        // ---------------- async reset mid-DRIVE ----------------
        wr_valid = 1'b1;
        wr_data  = 8'h96;
        step();
        wr_valid = 1'b0;
        chk("pre-reset pad_oe", 32'(pad_oe), 32'hFF);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        chk_all("reset held", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        step();

        // ---------------- randomized run vs timeline model ----------------
        busy_end = -1; drv_first = -1; drv_last = -1; rdv_cyc = -1; nout_at = -1;
        m_out = '0; m_nout = '0; m_rd = '0; m_rdn = '0;
        for (int t = 0; t < 800; t++) begin
            if (t == nout_at) m_out = m_nout;
            if (t == rdv_cyc) m_rd  = m_rdn;
            m_idle  = (t > busy_end);
            m_ready = m_idle || (t == drv_last);
            m_oe    = (t >= drv_first) && (t <= drv_last);
            chk_all($sformatf("rnd t%0d", t), m_oe, m_out, m_ready, !m_idle,
                    (t == rdv_cyc), m_rd, 1'b0);

            wr_valid = ($urandom % 3) == 0;
            wr_data  = W'($urandom);
            rd_req   = ($urandom % 3) == 0;
            err_clr  = ($urandom % 5) == 0;
            // External bus value only moves while no read can be sampling it
            if (m_idle && !rd_req && (($urandom % 4) == 0)) ext_val = W'($urandom);

            if (wr_valid && m_ready) begin
                if (m_idle) drv_first = t + 1;
                drv_last = t + int'(H);
                busy_end = t + int'(H + T);
                m_nout   = wr_data;
                nout_at  = t + 1;
            end else if (m_idle && rd_req) begin
                busy_end = t + int'(S);
                rdv_cyc  = t + int'(S) + 1;
                m_rdn    = ext_val;
            end
            step();
        end
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        err_clr  = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tri_bus_port.md
# tri_bus_port

Parametrised bidirectional bus port for Efinix devices: a WIDTH-bit tri-state pad is driven through three split signals (pad_in / pad_out / pad_oe) that map onto the GPIO block's input, output and output-enable. The core logic sees clean valid/ready write and request/valid read interfaces. The block owns bus direction and guarantees a programmable hold time and turnaround gap. It also synchronises sampled pad data. It sits between core logic and the top-level GPIO wrapper, one instance per shared bus.

## Interface
- WIDTH, 8: bus width in bits.
- HOLD_CYCLES, 2: cycles each write word is driven (min 1).
- TURN_CYCLES, 1: released cycles after a write before returning to idle (min 1).
- SYNC_STAGES, 2: pad_in synchroniser depth (min 2).
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- pad_in  in  WIDTH  value from GPIO input buffer.
- pad_out  out  WIDTH  value to GPIO output buffer.
- pad_oe  out  WIDTH  per-bit output enable; all bits always equal.
- wr_valid  in  1  write word offered.
- wr_data  in  WIDTH  write word.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- rd_req  in  1  read request (level, sampled in IDLE).
- rd_valid  out  1  one-cycle pulse; rd_data valid.
- rd_data  out  WIDTH  captured bus value.
- busy  out  1  high in any state other than IDLE.
- err_clr  in  1  clears contention_err.
- contention_err  out  1  sticky drive/readback mismatch flag.

## Operation
- States: IDLE, DRIVE, TURN, SAMPLE. Reset state IDLE.
- Reset values: pad_oe=0, pad_out=0, rd_data=0, rd_valid=0, contention_err=0. wr_ready is forced 0 while rst is high.
- pad_in passes through SYNC_STAGES flops. All reads and checks use the synchroniser output (sync_q).
- IDLE: pad_oe=0, wr_ready=1.
  - If wr_valid, accept: load pad_out=wr_data and go to DRIVE.
  - Else if rd_req, go to SAMPLE.
  - Write wins when both are asserted.
- DRIVE: pad_oe all ones for HOLD_CYCLES cycles. wr_ready=1 only on the last DRIVE cycle.
  - Write accepted on the last cycle: reload pad_out and restart DRIVE with no gap and pad_oe held high.
  - Otherwise go to TURN.
- TURN: pad_oe=0 for TURN_CYCLES cycles, wr_ready=0, rd_req ignored. pad_out holds the last word. Then go to IDLE.
- SAMPLE: pad_oe=0 for SYNC_STAGES cycles.
  - On the last cycle, register rd_data=sync_q.
  - The next cycle is IDLE with rd_valid=1, and a new transaction may be accepted in that cycle.
- Internal counters are sized to max(HOLD_CYCLES, TURN_CYCLES, SYNC_STAGES). They reset to 0 on every state entry.
- Asserting rst mid-transaction releases pad_oe immediately (async). The transaction is discarded and no rd_valid is produced.

## Timing
- Write accepted at edge k: pad_oe=1 and pad_out=word during cycles k+1..k+HOLD_CYCLES.
- Without a follow-on write: released during k+HOLD_CYCLES+1..k+HOLD_CYCLES+TURN_CYCLES; IDLE at k+HOLD_CYCLES+TURN_CYCLES+1.
- Back-to-back write throughput: one word per HOLD_CYCLES cycles.
- Read accepted at edge k: rd_valid high in cycle k+SYNC_STAGES+1.
  - rd_data reflects the pad value at roughly edge k+1 (synchroniser latency).
  - rd_data holds until the next read completes.
- pad_oe and pad_out are registered; there is no combinational path from inputs to pad outputs.

## Configuration
- TRI_BUS_READBACK_CHECK_EN defined: on the last DRIVE cycle, sync_q is compared with pad_out.
  - Any mismatch sets contention_err, which stays set until err_clr or rst.
  - err_clr and a mismatch in the same cycle leave the flag set.
  - Requires HOLD_CYCLES > SYNC_STAGES; elaboration error otherwise.
- Undefined: the comparator is removed and contention_err is tied 0. err_clr is ignored but the port remains, so the interface is unchanged.

## Test plan
- Reset: rst high mid-DRIVE with WIDTH=8 -> pad_oe=0 the same cycle; all outputs at reset values; wr_ready=0 until rst drops.
- Single write 0xA5, HOLD=2, TURN=1, accepted at edge 0 -> pad_oe=0xFF and pad_out=0xA5 in cycles 1–2; pad_oe=0 in cycle 3; IDLE with wr_ready=1 in cycle 4.
- Back-to-back writes 0x11, 0x22, 0x33 with wr_valid held -> pad_oe high continuously for 6 cycles; pad_out changes every 2 cycles; a single TURN cycle follows.
- Read with pad_in=0x3C and SYNC_STAGES=2, rd_req at edge 0 -> rd_valid pulses in cycle 3 with rd_data=0x3C. Simultaneous wr_valid+rd_req -> write first, read after TURN.
- Readback (macro on, HOLD=3): force pad_in=0x00 while driving 0xFF -> contention_err=1 from the cycle after the last DRIVE cycle; err_clr pulse -> 0. Macro off -> stays 0.
